// File: rtl/ps2_decode_pkg.sv
// Shared scan constants, prefix-state encoding and the set-2 make-code lookup
// used by the PS/2 scan decoder.
package ps2_decode_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  // Returns {hit, char}. Enter yields 8'h0D here; the top substitutes its
  // configurable code because a package function cannot see module parameters.
  function automatic logic [8:0] scan_to_char(input logic [7:0] scan, input logic shift);
    logic [8:0] res;
    logic [7:0] up;
    res = 9'h000;
    up  = 8'h00;
    case (scan)
      8'h1C: up = 8'h41;
      8'h32: up = 8'h42;
      8'h21: up = 8'h43;
      8'h23: up = 8'h44;
      8'h24: up = 8'h45;
      8'h2B: up = 8'h46;
      8'h34: up = 8'h47;
      8'h33: up = 8'h48;
      8'h43: up = 8'h49;
      8'h3B: up = 8'h4A;
      8'h42: up = 8'h4B;
      8'h4B: up = 8'h4C;
      8'h3A: up = 8'h4D;
      8'h31: up = 8'h4E;
      8'h44: up = 8'h4F;
      8'h4D: up = 8'h50;
      8'h15: up = 8'h51;
      8'h2D: up = 8'h52;
      8'h1B: up = 8'h53;
      8'h2C: up = 8'h54;
      8'h3C: up = 8'h55;
      8'h2A: up = 8'h56;
      8'h1D: up = 8'h57;
      8'h22: up = 8'h58;
      8'h35: up = 8'h59;
      8'h1A: up = 8'h5A;
      8'h45: res = {1'b1, 8'h30};
      8'h16: res = {1'b1, 8'h31};
      8'h1E: res = {1'b1, 8'h32};
      8'h26: res = {1'b1, 8'h33};
      8'h25: res = {1'b1, 8'h34};
      8'h2E: res = {1'b1, 8'h35};
      8'h36: res = {1'b1, 8'h36};
      8'h3D: res = {1'b1, 8'h37};
      8'h3E: res = {1'b1, 8'h38};
      8'h46: res = {1'b1, 8'h39};
      SC_SPACE: res = {1'b1, 8'h20};
      SC_BKSP:  res = {1'b1, 8'h08};
      SC_ENTER: res = {1'b1, 8'h0D};
      default:  res = 9'h000;
    endcase
    if (up != 8'h00) begin
      res = {1'b1, shift ? up : (up | 8'h20)};
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Scan-byte input and character-output handshake bundle of the PS/2 decoder.
interface ps2_scan_decoder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic             scan_valid;
  logic [7:0]       scan_ip;
  logic [7:0]       ascii_op;
  logic             ascii_valid;
  logic             ascii_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output scan_valid, scan_ip, ascii_ready,
    input  ascii_op, ascii_valid, fifo_count, overflow
  );

  modport slave (
    input  scan_valid, scan_ip, ascii_ready,
    output ascii_op, ascii_valid, fifo_count, overflow
  );
endinterface

// File: rtl/ps2_char_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module ps2_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan decoder: prefix FSM, make-code translation and character FIFO.
// Optional shift tracking is enabled with the PS2_SHIFT_EN macro.
//
// state      | meaning
// ST_IDLE    | no prefix pending; next byte is a make code
// ST_BRK     | F0 seen; next byte is a released key
// ST_EXT     | E0 seen; next non-prefix byte is dropped
// ST_EXT_BRK | E0 F0 seen; next non-prefix byte is dropped
module ps2_scan_decoder
  import ps2_decode_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] ENTER_ASCII = 8'h13
) (
  input logic              clk,
  input logic              rst_n,
  ps2_scan_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  prefix_state_e    state_q, state_d;
  logic             make_v;
  logic             shift_w;
  logic [8:0]       lut;
  logic [7:0]       char_w;
  logic             push_req, pop_w;
  logic             full_w, empty_w;
  logic [CNT_W-1:0] count_w;
  logic             overflow_q, overflow_d;

  always_comb begin
    state_d = state_q;
    make_v  = 1'b0;
    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_ip == SC_BRK)      state_d = ST_BRK;
          else if (bus.scan_ip == SC_EXT) state_d = ST_EXT;
          else                            make_v  = 1'b1;
        end
        ST_BRK: begin
          if (bus.scan_ip == SC_BRK)      state_d = ST_BRK;
          else if (bus.scan_ip == SC_EXT) state_d = ST_EXT_BRK;
          else                            state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (bus.scan_ip == SC_BRK)      state_d = ST_EXT_BRK;
          else if (bus.scan_ip == SC_EXT) state_d = ST_EXT;
          else                            state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (bus.scan_ip == SC_BRK || bus.scan_ip == SC_EXT) state_d = ST_EXT_BRK;
          else                                                state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef PS2_SHIFT_EN
  logic shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic brk_v;

  // Left and right shift are tracked separately so releasing one keeps the other.
  always_comb begin
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    brk_v     = bus.scan_valid && (state_q == ST_BRK) &&
                (bus.scan_ip != SC_BRK) && (bus.scan_ip != SC_EXT);
    if (make_v && bus.scan_ip == SC_LSHIFT) shift_l_d = 1'b1;
    if (make_v && bus.scan_ip == SC_RSHIFT) shift_r_d = 1'b1;
    if (brk_v && bus.scan_ip == SC_LSHIFT)  shift_l_d = 1'b0;
    if (brk_v && bus.scan_ip == SC_RSHIFT)  shift_r_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
    end else begin
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
    end
  end

  assign shift_w = shift_l_q | shift_r_q;
`else
  assign shift_w = 1'b1;
`endif

  assign lut      = scan_to_char(bus.scan_ip, shift_w);
  assign char_w   = (bus.scan_ip == SC_ENTER) ? ENTER_ASCII : lut[7:0];
  assign push_req = make_v && lut[8];
  assign pop_w    = !empty_w && bus.ascii_ready;

  assign overflow_d = overflow_q | (push_req && full_w && !pop_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  ps2_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .din_i   (char_w),
    .pop_i   (pop_w),
    .dout_o  (bus.ascii_op),
    .full_o  (full_w),
    .empty_o (empty_w),
    .count_o (count_w)
  );

  assign bus.ascii_valid = !empty_w;
  assign bus.fifo_count  = count_w;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: single-byte vector table plus
// multi-byte sequences for prefixes, overflow, simultaneous push/pop and reset.
module tb_ps2_scan_decoder;
  import ps2_decode_pkg::*;

`ifdef PS2_SHIFT_EN
  localparam logic [7:0] LC = 8'h20;
`else
  localparam logic [7:0] LC = 8'h00;
`endif

  typedef struct {
    logic [7:0] scan;
    logic       hit;
    logic [7:0] ch;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  logic [7:0] got[$];

  ps2_scan_decoder_if #(.FIFO_DEPTH(4)) bus ();

  ps2_scan_decoder #(.FIFO_DEPTH(4), .ENTER_ASCII(8'h13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.ascii_valid && bus.ascii_ready) got.push_back(bus.ascii_op);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.scan_valid = 1'b1;
    bus.scan_ip    = b;
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.scan_valid  = 1'b0;
    bus.scan_ip     = 8'h00;
    bus.ascii_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    bus.ascii_ready = 1'b1;
    while (bus.ascii_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.ascii_ready = 1'b0;
    chk({nm, " drain timeout"}, int'(n >= 20), 0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{8'h1C, 1'b1, 8'h41 | LC};
    vecs[1]  = '{8'h32, 1'b1, 8'h42 | LC};
    vecs[2]  = '{8'h1A, 1'b1, 8'h5A | LC};
    vecs[3]  = '{8'h45, 1'b1, 8'h30};
    vecs[4]  = '{8'h46, 1'b1, 8'h39};
    vecs[5]  = '{8'h29, 1'b1, 8'h20};
    vecs[6]  = '{8'h66, 1'b1, 8'h08};
    vecs[7]  = '{8'h5A, 1'b1, 8'h13};
    vecs[8]  = '{8'hAA, 1'b0, 8'h00};
    vecs[9]  = '{8'hFA, 1'b0, 8'h00};
    vecs[10] = '{8'h12, 1'b0, 8'h00};
    vecs[11] = '{8'h0E, 1'b0, 8'h00};

    bus.scan_valid  = 1'b0;
    bus.scan_ip     = 8'h00;
    bus.ascii_ready = 1'b0;
    do_reset();

    chk("reset count", int'(bus.fifo_count), 0);
    chk("reset valid", int'(bus.ascii_valid), 0);
    chk("reset op", int'(bus.ascii_op), 0);
    chk("reset overflow", int'(bus.overflow), 0);

    // Single-byte make codes, one at a time, popped after each check.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].scan);
      chk($sformatf("vec%0d count", i), int'(bus.fifo_count), int'(vecs[i].hit));
      chk($sformatf("vec%0d valid", i), int'(bus.ascii_valid), int'(vecs[i].hit));
      if (vecs[i].hit) begin
        chk($sformatf("vec%0d char", i), int'(bus.ascii_op), int'(vecs[i].ch));
        bus.ascii_ready = 1'b1;
        @(negedge clk);
        bus.ascii_ready = 1'b0;
        chk($sformatf("vec%0d popped", i), int'(bus.fifo_count), 0);
      end
    end
    chk("vec overflow", int'(bus.overflow), 0);

    // Press and release A with the consumer always ready.
    do_reset();
    bus.ascii_ready = 1'b1;
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    repeat (2) @(negedge clk);
    bus.ascii_ready = 1'b0;
    chk("press-release n", got.size(), 1);
    if (got.size() >= 1) chk("press-release char", int'(got[0]), int'(8'h41 | LC));

    // Shift held around the first A only.
    do_reset();
    bus.ascii_ready = 1'b1;
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    repeat (2) @(negedge clk);
    bus.ascii_ready = 1'b0;
    chk("shift n", got.size(), 2);
    if (got.size() >= 2) begin
      chk("shift ch0", int'(got[0]), 8'h41);
      chk("shift ch1", int'(got[1]), int'(8'h41 | LC));
    end

    // Extended and break prefixes plus unmapped codes push nothing.
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0);
    send(8'h75); send(8'hAA); send(8'hFA); send(8'h0E);
    chk("ext count", int'(bus.fifo_count), 0);
    chk("ext valid", int'(bus.ascii_valid), 0);
    chk("ext overflow", int'(bus.overflow), 0);

    // Fill past capacity with the consumer stalled.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    chk("fill overflow early", int'(bus.overflow), 0);
    send(8'h2E);
    chk("full count", int'(bus.fifo_count), 4);
    chk("full overflow", int'(bus.overflow), 1);
    chk("full head", int'(bus.ascii_op), 8'h31);
    drain("ovf");
    chk("ovf drained n", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("ovf ch%0d", i), int'(got[i]), 8'h31 + i);
    chk("ovf sticky", int'(bus.overflow), 1);
    chk("ovf empty", int'(bus.fifo_count), 0);

    // Push into a full FIFO in the same cycle as a pop.
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    @(negedge clk);
    bus.ascii_ready = 1'b1;
    bus.scan_valid  = 1'b1;
    bus.scan_ip     = 8'h45;
    @(negedge clk);
    bus.ascii_ready = 1'b0;
    bus.scan_valid  = 1'b0;
    chk("pp count", int'(bus.fifo_count), 4);
    chk("pp overflow", int'(bus.overflow), 0);
    chk("pp head", int'(bus.ascii_op), 8'h32);
    drain("pp");
    chk("pp n", got.size(), 5);
    if (got.size() == 5) chk("pp last", int'(got[4]), 8'h30);

    // Reset asserted with a break prefix pending and entries queued.
    do_reset();
    send(8'h16); send(8'h1E); send(8'hF0);
    chk("pre-rst count", int'(bus.fifo_count), 2);
    rst_n = 1'b0;
    #1;
    chk("mid-rst count", int'(bus.fifo_count), 0);
    chk("mid-rst valid", int'(bus.ascii_valid), 0);
    chk("mid-rst op", int'(bus.ascii_op), 0);
    chk("mid-rst overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A);
    chk("post-rst count", int'(bus.fifo_count), 1);
    chk("post-rst enter", int'(bus.ascii_op), 8'h13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Parametrised successor to the single-byte scan-code lookup in the keyboard input path. It accepts a stream of PS/2 set-2 scan bytes and tracks break (F0) and extended (E0) prefixes, so each key press produces exactly one character and releases produce none. Translated characters are buffered in an output FIFO with a valid/ready handshake. It sits between the PS/2 byte receiver and the command/operand parser of the CORDIC front end.

## Interface
- FIFO_DEPTH, 4, character FIFO entries; power of two, ≥2
- ENTER_ASCII, 8'h13, code emitted for Enter (scan 5A)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- scan_valid  in  1  scan_ip holds a new byte this cycle (single-cycle strobe)
- scan_ip  in  8  PS/2 set-2 scan byte
- ascii_op  out  8  FIFO head character (show-ahead)
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts ascii_op this cycle
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held
- overflow  out  1  sticky: a character was dropped because the FIFO was full

## Operation
- Prefix FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions occur only on scan_valid.
  - IDLE: F0→BRK; E0→EXT; otherwise stay in IDLE and process as a make code.
  - BRK: F0→BRK; E0→EXT_BRK; otherwise consume as a break code →IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; otherwise drop →IDLE.
  - EXT_BRK: F0/E0 stay; otherwise drop →IDLE.
- Make-code map:
  - Letters A–Z: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - Digits 0–9: 45,16,1E,26,25,2E,36,3D,3E,46 → 30–39.
  - Space: 29→20. Backspace: 66→08. Enter: 5A→ENTER_ASCII.
- Unmapped make codes, including AA (BAT) and FA (ack), are dropped. Nothing is pushed; there is no 00 output.
- Typematic repeats (a make code without an intervening break) push once per byte.
- FIFO push: a mapped make code pushes if fifo_count<FIFO_DEPTH, or if the FIFO is full but a pop occurs in the same cycle. Otherwise the character is dropped and overflow is set.
- Pop: a pop occurs when ascii_valid && ascii_ready.
- Reset values: state=IDLE, shift=0, fifo_count=0, ascii_valid=0, ascii_op=8'h00, overflow=0. overflow is cleared only by reset.
- Reset mid-sequence (for example after F0) discards the prefix. The next byte is treated as a make code.

## Timing
- Byte accepted at edge N: the push is visible at edge N+1. If the FIFO was empty, ascii_valid=1 and ascii_op is valid from N+1, giving a latency of 1 cycle.
- Pop at edge M: the next entry appears on ascii_op after edge M. fifo_count updates at the same edge.
- Push and pop in the same cycle leave fifo_count unchanged. With the FIFO empty, a same-cycle push and pop is impossible because ascii_valid=0.
- ascii_op when the FIFO is empty is don't-care, but must hold 8'h00 after reset.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Configuration
- PS2_SHIFT_EN defined:
  - Shift codes 12 and 59 set the shift flag on make and clear it on break. Either key held keeps shift=1; track each key separately.
  - Letters map to lowercase (61–7A) when shift=0 and uppercase (41–5A) when shift=1. Digits are unaffected.
  - Shift codes push nothing.
- PS2_SHIFT_EN undefined:
  - No shift state exists. Letters are always uppercase.
  - 12 and 59 are unmapped and dropped.

## Structure
- Package ps2_decode_pkg contains:
  - scan constants (F0, E0, shift, Enter, Space, Backspace);
  - the FSM state enum;
  - a pure function scan_to_char(scan, shift) returning {hit, char}.
- Sub-module ps2_char_fifo: a synchronous show-ahead FIFO parametrised by DEPTH and width 8. It provides push, pop, full, empty and count, and implements the same-cycle full-push-with-pop rule.
- The top level holds the FSM, shift flags, overflow flag and the push decision.

## Test plan
- Bytes 1C, F0, 1C with ascii_ready=1 → exactly one character: 41 without PS2_SHIFT_EN, 61 with it. ascii_valid pulses for 1 cycle.
- With PS2_SHIFT_EN: 12, 1C, F0, 1C, F0, 12, 1C → characters 41 then 61.
- Bytes E0, 75, E0, F0, 75, AA, FA, 0E → no pushes; fifo_count stays 0; overflow=0.
- FIFO_DEPTH=4, ascii_ready=0, make codes 16, 1E, 26, 25, 2E → FIFO holds 31–34; 35 is dropped; overflow=1. Then raise ascii_ready → 31, 32, 33, 34 appear in order.
- FIFO full with ascii_ready=1 and 45 arriving in the same cycle → pop and push both occur; fifo_count stays 4; overflow remains 0; 30 appears last.
- Assert rst_n low after F0 while 2 entries are queued → all outputs return to reset values. Next byte 5A → ascii_op=ENTER_ASCII (13).
